// File: rtl/ex_stage.sv
// Execute stage: ID->EX pipeline register, ALU, data-SRAM request, EX->ID forwarding,
// and an iterative (32-step) multiply/divide unit that owns HI/LO.
module ex_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  input  logic [158:0] id_to_ex_bus,
  output logic [75:0]  ex_to_mem_bus,
  output logic [37:0]  ex_to_id_bus,
  output logic         is_lw,
  output logic         stallreq_from_ex,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_wen,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata
);
  localparam logic       Stop   = 1'b1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // ---------------- ID->EX register ----------------
  logic [158:0] ex_q, ex_d;

  always_comb begin
    ex_d = ex_q;
    if (stall[2] == Stop && stall[3] != Stop) ex_d = '0;
    else if (stall[2] != Stop)                ex_d = id_to_ex_bus;
  end

  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  logic [31:0] pc, inst, rdata1, rdata2;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2;
  logic        ram_en, rf_we, sel_rf_res;
  logic [3:0]  ram_wen;
  logic [4:0]  rf_waddr;

  assign pc         = ex_q[158:127];
  assign inst       = ex_q[126:95];
  assign alu_op     = ex_q[94:83];
  assign sel_src1   = ex_q[82:80];
  assign sel_src2   = ex_q[79:76];
  assign ram_en     = ex_q[75];
  assign ram_wen    = ex_q[74:71];
  assign rf_we      = ex_q[70];
  assign rf_waddr   = ex_q[69:65];
  assign sel_rf_res = ex_q[64];
  assign rdata1     = ex_q[63:32];
  assign rdata2     = ex_q[31:0];

  // ---------------- operands and ALU ----------------
  logic [31:0] src1, src2;

  always_comb begin
    src1 = rdata1;
    if (sel_src1[1])      src1 = pc;
    else if (sel_src1[2]) src1 = {27'b0, inst[10:6]};
  end

  assign src2 = ({32{sel_src2[0]}} & rdata2)
              | ({32{sel_src2[1]}} & {{16{inst[15]}}, inst[15:0]})
              | ({32{sel_src2[2]}} & 32'd8)
              | ({32{sel_src2[3]}} & {16'b0, inst[15:0]});

  logic [31:0] add_r, sub_r, slt_r, sltu_r, sll_r, srl_r, sra_r, lui_r, alu_res;

  assign add_r  = src1 + src2;
  assign sub_r  = src1 - src2;
  assign slt_r  = {31'b0, ($signed(src1) < $signed(src2))};
  assign sltu_r = {31'b0, (src1 < src2)};
  assign sll_r  = src2 << src1[4:0];
  assign srl_r  = src2 >> src1[4:0];
  assign sra_r  = $signed(src2) >>> src1[4:0];
  assign lui_r  = {src2[15:0], 16'b0};

  // alu_op is one-hot, so an AND-OR mux suffices and all-zero yields 0
  assign alu_res = ({32{alu_op[11]}} & add_r)
                 | ({32{alu_op[10]}} & sub_r)
                 | ({32{alu_op[9]}}  & slt_r)
                 | ({32{alu_op[8]}}  & sltu_r)
                 | ({32{alu_op[7]}}  & (src1 & src2))
                 | ({32{alu_op[6]}}  & ~(src1 | src2))
                 | ({32{alu_op[5]}}  & (src1 | src2))
                 | ({32{alu_op[4]}}  & (src1 ^ src2))
                 | ({32{alu_op[3]}}  & sll_r)
                 | ({32{alu_op[2]}}  & srl_r)
                 | ({32{alu_op[1]}}  & sra_r)
                 | ({32{alu_op[0]}}  & lui_r);

  // ---------------- SPECIAL decode for HI/LO ops ----------------
  logic       special, is_md, md_signed, md_div;
  logic       is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic [5:0] funct;

  assign special   = (inst[31:26] == 6'b0);
  assign funct     = inst[5:0];
  assign is_md     = special && (funct[5:2] == 4'b0110);
  assign md_signed = ~funct[0];
  assign md_div    = funct[1];
  assign is_mfhi   = special && (funct == 6'h10);
  assign is_mthi   = special && (funct == 6'h11);
  assign is_mflo   = special && (funct == 6'h12);
  assign is_mtlo   = special && (funct == 6'h13);

  // ---------------- mul/div unit ----------------
  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d, opb_q, opb_d;
  logic [63:0] acc_q, acc_d;
  logic        div_q, div_d, negq_q, negq_d, negr_q, negr_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        a_neg, b_neg, md_last;
  logic [31:0] a_abs, b_abs;
  logic [32:0] rem_sh, rem_diff;
  logic [63:0] div_step, mul_step, acc_nxt, prod;
  logic [31:0] fin_hi, fin_lo;

  assign a_neg = md_signed & rdata1[31];
  assign b_neg = md_signed & rdata2[31];
  assign a_abs = a_neg ? (32'd0 - rdata1) : rdata1;
  assign b_abs = b_neg ? (32'd0 - rdata2) : rdata2;

  // Divide: acc holds {remainder, quotient}; quotient bits shift in at the bottom
  assign rem_sh   = acc_q[63:31];
  assign rem_diff = rem_sh - {1'b0, opb_q};
  assign div_step = rem_diff[32] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                                 : {rem_diff[31:0], acc_q[30:0], 1'b1};
  assign mul_step = acc_q + (opb_q[cnt_q] ? ({32'b0, opa_q} << cnt_q) : 64'd0);
  assign acc_nxt  = div_q ? div_step : mul_step;

  assign prod    = negq_q ? (64'd0 - acc_nxt) : acc_nxt;
  assign md_last = (state_q == S_BUSY) && (cnt_q == 5'd31);

  // Zero divisor leaves remainder = |rs| naturally; only the quotient needs forcing
  always_comb begin
    fin_hi = prod[63:32];
    fin_lo = prod[31:0];
    if (div_q) begin
      fin_hi = negr_q ? (32'd0 - acc_nxt[63:32]) : acc_nxt[63:32];
      fin_lo = (opb_q == 32'd0) ? 32'hFFFF_FFFF
             : (negq_q ? (32'd0 - acc_nxt[31:0]) : acc_nxt[31:0]);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    div_d   = div_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    case (state_q)
      S_IDLE: if (is_md) begin
        state_d = S_BUSY;
        cnt_d   = 5'd0;
        opa_d   = a_abs;
        opb_d   = b_abs;
        acc_d   = md_div ? {32'b0, a_abs} : 64'd0;
        div_d   = md_div;
        negq_d  = a_neg ^ b_neg;
        negr_d  = a_neg;
      end
      S_BUSY: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (md_last) begin
      hi_d = fin_hi;
      lo_d = fin_lo;
    end else begin
      if (is_mthi) hi_d = rdata1;
      if (is_mtlo) lo_d = rdata1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      div_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      div_q   <= div_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign stallreq_from_ex = ((state_q == S_IDLE) && is_md) || (state_q == S_BUSY);

  // ---------------- writeback view and outputs ----------------
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_res;

  always_comb begin
    wb_we   = rf_we;
    wb_addr = rf_waddr;
    wb_res  = alu_res;
    if (is_md) wb_we = 1'b0;
    if (is_mfhi || is_mflo) begin
      wb_we   = 1'b1;
      wb_addr = inst[15:11];
      wb_res  = is_mfhi ? hi_q : lo_q;
    end
  end

  assign ex_to_mem_bus   = {pc, ram_en, ram_wen, sel_rf_res, wb_we, wb_addr, wb_res};
  assign ex_to_id_bus    = {wb_we, wb_addr, wb_res};
  assign is_lw           = ram_en && (ram_wen == 4'b0);
  assign data_sram_en    = ram_en;
  assign data_sram_wen   = ram_wen;
  assign data_sram_addr  = alu_res;
  assign data_sram_wdata = rdata2;

  logic unused_bits;
  assign unused_bits = ^{stall[5:4], stall[1:0], sel_src1[0], inst[25:16]};

endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against a behavioural model (arithmetic HI/LO, cycle-count timeline).
module tb_ex_stage;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [5:0]   stall = '0;
  logic [158:0] id_bus = '0;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_id_bus;
  logic         is_lw, stallreq_from_ex, data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr, data_sram_wdata;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_bus),
    .ex_to_mem_bus(ex_to_mem_bus), .ex_to_id_bus(ex_to_id_bus), .is_lw(is_lw),
    .stallreq_from_ex(stallreq_from_ex), .data_sram_en(data_sram_en),
    .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata)
  );

  int n_vec = 0;
  int n_err = 0;

  // model state: EX register contents, HI/LO, and position in the md timeline
  // (phase 0 idle, k = k-th busy cycle 1..32, 33 = done cycle)
  logic [158:0] m_ex = '0;
  logic [31:0]  m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
  logic [5:0]   m_f = '0;
  int           m_phase = 0;

  function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
      input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2, input logic ren,
      input logic [3:0] wen, input logic we, input logic [4:0] wa, input logic sres,
      input logic [31:0] r1, input logic [31:0] r2);
    return {pc, inst, op, s1, s2, ren, wen, we, wa, sres, r1, r2};
  endfunction

  function automatic logic [158:0] sp(input logic [5:0] f, input logic [31:0] r1, input logic [31:0] r2);
    return mk(32'h0040_0100, {6'h0, 5'd1, 5'd2, 5'd7, 5'd0, f}, 12'h0, 3'b0, 4'b0,
              1'b0, 4'b0, 1'b1, 5'd7, 1'b0, r1, r2);
  endfunction

  function automatic logic is_md_op(input logic [158:0] b);
    return (b[126:121] == 6'h0) && (b[100:95] >= 6'h18) && (b[100:95] <= 6'h1B);
  endfunction

  function automatic logic [31:0] alu_ref(input logic [158:0] b);
    logic [31:0] inst, a, c, r;
    inst = b[126:95];
    if (b[81])      a = b[158:127];
    else if (b[82]) a = {27'b0, inst[10:6]};
    else            a = b[63:32];
    if (b[76])      c = b[31:0];
    else if (b[77]) c = {{16{inst[15]}}, inst[15:0]};
    else if (b[78]) c = 32'd8;
    else if (b[79]) c = {16'b0, inst[15:0]};
    else            c = 32'd0;
    case (b[94:83])
      12'h800: r = a + c;
      12'h400: r = a - c;
      12'h200: r = ($signed(a) < $signed(c)) ? 32'd1 : 32'd0;
      12'h100: r = (a < c) ? 32'd1 : 32'd0;
      12'h080: r = a & c;
      12'h040: r = ~(a | c);
      12'h020: r = a | c;
      12'h010: r = a ^ c;
      12'h008: r = c << a[4:0];
      12'h004: r = c >> a[4:0];
      12'h002: r = $signed(c) >>> a[4:0];
      12'h001: r = {c[15:0], 16'b0};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic m_stall();
    return (m_phase == 0 && is_md_op(m_ex)) || (m_phase >= 1 && m_phase <= 32);
  endfunction

  task automatic md_finish();
    logic [63:0] p;
    case (m_f)
      6'h18: begin p = longint'($signed(m_a)) * longint'($signed(m_b)); m_hi = p[63:32]; m_lo = p[31:0]; end
      6'h19: begin p = {32'b0, m_a} * {32'b0, m_b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      6'h1A: begin
        if (m_b == 32'd0) begin m_lo = 32'hFFFF_FFFF; m_hi = m_a; end
        else if (m_a == 32'h8000_0000 && m_b == 32'hFFFF_FFFF) begin m_lo = 32'h8000_0000; m_hi = 32'd0; end
        else begin m_lo = $signed(m_a) / $signed(m_b); m_hi = $signed(m_a) % $signed(m_b); end
      end
      default: begin
        if (m_b == 32'd0) begin m_lo = 32'hFFFF_FFFF; m_hi = m_a; end
        else begin m_lo = m_a / m_b; m_hi = m_a % m_b; end
      end
    endcase
  endtask

  task automatic model_update(input logic [158:0] b, input logic [5:0] s, input logic r);
    logic sp_op;
    logic [5:0] f;
    if (r) begin
      m_ex = '0; m_hi = '0; m_lo = '0; m_phase = 0;
      return;
    end
    sp_op = (m_ex[126:121] == 6'h0);
    f = m_ex[100:95];
    if (m_phase == 0) begin
      if (is_md_op(m_ex)) begin m_phase = 1; m_a = m_ex[63:32]; m_b = m_ex[31:0]; m_f = f; end
    end else if (m_phase < 32) m_phase++;
    else if (m_phase == 32) begin md_finish(); m_phase = 33; end
    else m_phase = 0;
    if (sp_op && f == 6'h11) m_hi = m_ex[63:32];
    if (sp_op && f == 6'h13) m_lo = m_ex[63:32];
    if (s[2] && !s[3]) m_ex = '0;
    else if (!s[2])    m_ex = b;
  endtask

  task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] inst, res;
    logic we;
    logic [4:0] wa;
    logic sp_op;
    inst  = m_ex[126:95];
    sp_op = (inst[31:26] == 6'h0);
    we = m_ex[70]; wa = m_ex[69:65]; res = alu_ref(m_ex);
    if (is_md_op(m_ex)) we = 1'b0;
    if (sp_op && (inst[5:0] == 6'h10 || inst[5:0] == 6'h12)) begin
      we = 1'b1; wa = inst[15:11];
      res = (inst[5:0] == 6'h10) ? m_hi : m_lo;
    end
    chk("ex_to_mem_bus", ex_to_mem_bus, {m_ex[158:127], m_ex[75], m_ex[74:71], m_ex[64], we, wa, res});
    chk("ex_to_id_bus", {38'b0, ex_to_id_bus}, {38'b0, we, wa, res});
    chk("is_lw", {75'b0, is_lw}, {75'b0, (m_ex[75] && m_ex[74:71] == 4'b0)});
    chk("stallreq", {75'b0, stallreq_from_ex}, {75'b0, m_stall()});
    chk("sram_req", {7'b0, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
        {7'b0, m_ex[75], m_ex[74:71], alu_ref(m_ex), m_ex[31:0]});
  endtask

  // called at a negedge: drive, advance model across the next posedge, compare at next negedge
  task automatic apply(input logic [158:0] b, input logic [5:0] s, input logic r);
    id_bus = b; stall = s; rst = r;
    model_update(b, s, r);
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input logic [158:0] b);
    apply(b, m_stall() ? 6'b001111 : 6'b000000, 1'b0);
  endtask

  task automatic wait_md(input logic [158:0] nxt, output int n);
    n = 0;
    while (stallreq_from_ex === 1'b1 && n < 40) begin n++; run(nxt); end
    if (n >= 40) chk("md_timeout", 76'(n), 76'd33);
  endtask

  function automatic logic [31:0] rnd32();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 11))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = 32'h7FFF_FFFF;
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [158:0] rnd_bus();
    int k;
    logic [5:0] op6;
    logic [31:0] inst;
    logic [11:0] aop;
    int ai;
    k = $urandom_range(0, 99);
    if (k < 8)  return sp(6'h18 + 6'($urandom_range(0, 3)), rnd32(), rnd32());
    if (k < 16) return sp(($urandom_range(0, 1) != 0) ? 6'h10 : 6'h12, rnd32(), rnd32());
    if (k < 22) return sp(($urandom_range(0, 1) != 0) ? 6'h11 : 6'h13, rnd32(), rnd32());
    op6 = 6'($urandom_range(1, 63));
    inst = $urandom;
    inst[31:26] = op6;
    ai = $urandom_range(0, 12);
    aop = (ai < 12) ? (12'h001 << ai) : 12'h000;
    return mk($urandom, inst, aop, 3'($urandom_range(0, 7)), 4'b0001 << $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), rnd32(), rnd32());
  endfunction

  localparam logic [11:0] ADD = 12'h800;

  initial begin
    logic [158:0] addu, lw, mfhi, mflo;
    int n;
    logic [5:0] s;
    addu = mk(32'h0040_0000, {6'h0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, ADD, 3'b000, 4'b0001,
              1'b0, 4'b0, 1'b1, 5'd3, 1'b0, 32'd5, 32'd7);
    lw   = mk(32'h0040_0004, {6'h23, 5'd4, 5'd9, 16'hFFFC}, ADD, 3'b000, 4'b0010,
              1'b1, 4'b0, 1'b1, 5'd9, 1'b1, 32'h1000, 32'h0);
    mfhi = sp(6'h10, 32'd0, 32'd0);
    mflo = sp(6'h12, 32'd0, 32'd0);

    @(negedge clk);
    apply('0, 6'b0, 1'b1);
    apply(addu, 6'b0, 1'b1);
    chk("reset_mem_bus", ex_to_mem_bus, 76'd0);
    chk("reset_stallreq", {75'b0, stallreq_from_ex}, 76'd0);

    run(addu);
    chk("addu_mem_res", {44'b0, ex_to_mem_bus[31:0]}, 76'd12);
    chk("addu_id_res", {44'b0, ex_to_id_bus[31:0]}, 76'd12);
    chk("addu_sram_en", {75'b0, data_sram_en}, 76'd0);

    run(lw);
    chk("lw_addr", {44'b0, data_sram_addr}, 76'h0FFC);
    chk("lw_is_lw", {75'b0, is_lw}, 76'd1);
    chk("lw_waddr", {71'b0, ex_to_id_bus[36:32]}, 76'd9);

    run(sp(6'h19, 32'hFFFF_FFFF, 32'd2));
    wait_md(mfhi, n);
    chk("multu_stall_cycles", 76'(n), 76'd33);
    run(mfhi);
    chk("multu_hi", {44'b0, ex_to_id_bus[31:0]}, 76'h1);
    run(mflo);
    chk("multu_lo", {44'b0, ex_to_id_bus[31:0]}, 76'hFFFF_FFFE);

    run(sp(6'h1A, 32'hFFFF_FFF9, 32'd2));
    wait_md(mflo, n);
    run(mflo);
    chk("div_lo", {44'b0, ex_to_id_bus[31:0]}, 76'hFFFF_FFFD);
    run(mfhi);
    chk("div_hi", {44'b0, ex_to_id_bus[31:0]}, 76'hFFFF_FFFF);

    run(sp(6'h1B, 32'd9, 32'd0));
    wait_md(mflo, n);
    run(mflo);
    chk("divu0_lo", {44'b0, ex_to_id_bus[31:0]}, 76'hFFFF_FFFF);
    run(mfhi);
    chk("divu0_hi", {44'b0, ex_to_id_bus[31:0]}, 76'd9);

    run(sp(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF));
    wait_md(mflo, n);
    run(mflo);
    chk("divovf_lo", {44'b0, ex_to_id_bus[31:0]}, 76'h8000_0000);
    run(mfhi);
    chk("divovf_hi", {44'b0, ex_to_id_bus[31:0]}, 76'd0);

    // reset in the 11th busy cycle (iteration counter at 10)
    run(sp(6'h18, 32'd3, 32'd5));
    for (int i = 0; i < 11; i++) run(mfhi);
    apply('0, 6'b0, 1'b1);
    chk("rst_busy_stallreq", {75'b0, stallreq_from_ex}, 76'd0);
    run(mfhi);
    chk("rst_busy_hi", {44'b0, ex_to_id_bus[31:0]}, 76'd0);
    run(mflo);
    chk("rst_busy_lo", {44'b0, ex_to_id_bus[31:0]}, 76'd0);
    run(sp(6'h18, 32'hFFFF_FFFD, 32'd5));
    wait_md(mfhi, n);
    run(mfhi);
    chk("mult_after_rst_hi", {44'b0, ex_to_id_bus[31:0]}, 76'hFFFF_FFFF);
    run(mflo);
    chk("mult_after_rst_lo", {44'b0, ex_to_id_bus[31:0]}, 76'hFFFF_FFF1);

    run(addu);
    apply(lw, 6'b000111, 1'b0);
    chk("bubble_mem_bus", ex_to_mem_bus, 76'd0);

    for (int i = 0; i < 3000; i++) begin
      if (m_stall()) s = 6'b001111;
      else case ($urandom_range(0, 9))
        0: s = 6'b000111;
        1: s = 6'b001111;
        default: s = 6'b000000;
      endcase
      apply(rnd_bus(), s, ($urandom_range(0, 399) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline, between ID and MEM. Registers the ID→EX bus, runs the ALU, and issues the data-SRAM request. Drives the EX→ID forwarding bus and the load-use flag. Owns HI/LO and a 32-iteration multiply/divide unit, which stalls the pipeline while busy.

## Interface
- No parameters; `StallBus`=6, `ID_TO_EX_WD`=159, `EX_TO_MEM_WD`=76, `EX_TO_ID_WD`=38 from `lib/defines.vh`.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stall  in  StallBus  stall vector; bit 2 = EX input reg, bit 3 = MEM input reg; `Stop`=1.
- id_to_ex_bus  in  159  {pc[158:127], inst[126:95], alu_op[94:83], sel_src1[82:80], sel_src2[79:76], ram_en[75], ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rdata1[63:32], rdata2[31:0]}.
- ex_to_mem_bus  out  76  {pc[75:44], ram_en[43], ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], result[31:0]}.
- ex_to_id_bus  out  38  {rf_we[37], rf_waddr[36:32], result[31:0]}.
- is_lw  out  1  EX holds a load (ram_en & ram_wen==0).
- stallreq_from_ex  out  1  mul/div in progress.
- data_sram_en  out  1  = ram_en.
- data_sram_wen  out  4  = ram_wen.
- data_sram_addr  out  32  = ALU result.
- data_sram_wdata  out  32  = rdata2.

## Operation
- Input register:
  - rst → 0.
  - Else stall[2]=Stop & stall[3]=NoStop → 0 (bubble).
  - Else stall[2]=NoStop → load id_to_ex_bus.
  - Else hold.
- Operand src1:
  - sel_src1[1] → pc.
  - sel_src1[2] → {27'b0, inst[10:6]}.
  - Otherwise → rdata1.
- Operand src2 (one-hot):
  - [0] rdata2.
  - [1] sign-ext inst[15:0].
  - [2] 32'd8.
  - [3] zero-ext inst[15:0].
- ALU, alu_op one-hot {add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui}:
  - add/sub are modulo 2^32.
  - slt signed, sltu unsigned; both return 0/1.
  - Shifts apply to src2 by src1[4:0]; sra is arithmetic.
  - lui = {src2[15:0], 16'b0}.
  - All-zero alu_op → result 0.
- EX decodes SPECIAL (opcode 0) funct itself:
  - mult 0x18, multu 0x19, div 0x1A, divu 0x1B: rf_we forced to 0.
  - mfhi 0x10, mflo 0x12: rf_we=1, rf_waddr=inst[15:11], result=HI/LO.
  - mthi 0x11, mtlo 0x13: HI/LO ← rdata1 at end of the cycle.
- Mul/div FSM, states IDLE, BUSY, DONE:
  - IDLE + md op in EX → latch |rs|, |rt| (signed ops) or raw values, and the sign flags; cnt←0; go to BUSY.
  - BUSY: one shift-add (mul) or restoring shift-subtract (div) step per cycle. At cnt=31, sign-correct, write {HI,LO}, go to DONE.
  - DONE → IDLE unconditionally. A new md op is never started from DONE.
- Results:
  - mul: {HI,LO} = 64-bit product.
  - div: LO = quotient, HI = remainder; remainder takes the dividend's sign.
- Division boundaries:
  - Divide by zero (any signedness): LO=32'hFFFFFFFF, HI=rs, no exception.
  - 0x80000000 / -1: LO=0x80000000, HI=0.
- stallreq_from_ex = (IDLE & md op in EX) | BUSY.

## Timing
- ALU, forwarding, and SRAM outputs are combinational from the EX register: 0-cycle latency within EX.
- Mul/div timeline:
  - Cycle 0: op sits in EX, stallreq=1.
  - Cycles 1–32: BUSY, stallreq=1.
  - End of cycle 32: HI/LO written.
  - Cycle 33: DONE, stallreq=0; EX register loads the next instruction at the end of cycle 33.
  - Total stall: 33 cycles.
- mfhi/mflo immediately after an md op reads the updated HI/LO.
- Reset values:
  - All outputs 0.
  - HI=LO=0, FSM IDLE, cnt=0.
- rst mid-BUSY: next cycle FSM is IDLE, stallreq=0, and HI/LO=0 (partial result discarded).
- stall[2]=Stop with stall[3]=Stop: EX holds. A repeated mthi/mtlo write is idempotent.

## Test plan
- addu, rdata1=5, rdata2=7, alu_op=add, sel_src2[0] → result=12 on ex_to_mem and ex_to_id; data_sram_en=0.
- lw, rdata1=0x1000, imm=0xFFFC → data_sram_addr=0x0FFC, is_lw=1, ex_to_id_bus[36:32]=rt.
- multu 0xFFFFFFFF×2 then mfhi/mflo → stallreq high exactly 33 cycles; HI=1, LO=0xFFFFFFFE.
- div −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu 9/0 → LO=0xFFFFFFFF, HI=9.
- rst asserted at BUSY cnt=10 → stallreq=0 next cycle, HI=LO=0; a subsequent mult completes correctly.
- stall[2]=Stop, stall[3]=NoStop → bubble: next cycle ex_to_mem_bus=0.
